// File: rtl/cpu_pkg.sv
// Shared types and constants for the picoMIPS switch input-conditioning stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        OFFER    = 2'd1,
        WAIT_REL = 2'd2
    } sw_state_t;

    localparam int CAP_CNT_W         = 8;
    localparam int DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser, optional debounce filter (SW_DEBOUNCE_EN) and edge pulses
// for a single switch bit.
module sw_debounce
    import cpu_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       sw_s;
    logic       level;
    logic       level_dly_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign sw_s = sync_q[1];

`ifdef SW_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       level_q, level_d;

    // A new level is accepted only after DB_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sw_s != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sw_s;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    // Without the filter the synchronised level is used as-is; DB_CYCLES has no role.
    logic unused_db;
    assign unused_db = ^8'(DB_CYCLES);
    assign level     = sw_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_dly_q <= 1'b0;
        end else begin
            level_dly_q <= level;
        end
    end

    assign stable_o = level;
    assign rise_o   = level & ~level_dly_q;
    assign fall_o   = ~level & level_dly_q;

endmodule

// File: rtl/sw_input_ctrl.sv
// Switch input conditioning for the picoMIPS core: clean sw8 strobe, sws snapshot
// per press, valid/ready operand offer. Debounce enabled by defining SW_DEBOUNCE_EN.
module sw_input_ctrl
    import cpu_pkg::*;
#(
    parameter int N         = 8,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sw8,
    input  logic [N-1:0]         sws,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [N-1:0]         data_o,
    output logic                 sw8_clean_o,
    output logic [CAP_CNT_W-1:0] cap_cnt_o
);

    logic                 stable, rise, fall;
    logic [N-1:0]         sws_meta_q, sws_s_q;
    sw_state_t            state_q, state_d;
    logic                 valid_q, valid_d;
    logic [N-1:0]         data_q, data_d;
    logic [CAP_CNT_W-1:0] cnt_q, cnt_d;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw8_db (
        .clk      (clk),
        .reset    (reset),
        .d_i      (sw8),
        .stable_o (stable),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sws_sync
            always_ff @(posedge clk) begin
                if (!reset) begin
                    sws_meta_q[gi] <= 1'b0;
                    sws_s_q[gi]    <= 1'b0;
                end else begin
                    sws_meta_q[gi] <= sws[gi];
                    sws_s_q[gi]    <= sws_meta_q[gi];
                end
            end
        end
    endgenerate

    // After a transfer, a still-pressed switch must be released before re-arming.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARMED: begin
                if (rise) begin
                    data_d  = sws_s_q;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = stable ? WAIT_REL : ARMED;
                end
            end
            WAIT_REL: begin
                if (fall) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARMED;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign sw8_clean_o = stable;
    assign cap_cnt_o   = cnt_q;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Self-checking bench for sw_input_ctrl: directed scenarios plus random switch
// activity, all compared every cycle against a behavioural model of the press/offer rules.
module tb_sw_input_ctrl;

    localparam int N  = 8;
    localparam int DB = 4;
`ifdef SW_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LAT = DEB ? DB + 3 : 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         sw8;
    logic [N-1:0] sws;
    logic         ready_i;
    logic         valid_o;
    logic [N-1:0] data_o;
    logic         sw8_clean_o;
    logic [7:0]   cap_cnt_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic         m_pin_hist [2];
    logic [N-1:0] m_sws_hist [2];
    logic         m_stable, m_stable_prev;
    logic         m_valid, m_need_rel;
    logic [N-1:0] m_data;
    logic [7:0]   m_cnt;
    int           m_run;

    sw_input_ctrl #(.N(N), .DB_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw8         (sw8),
        .sws         (sws),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .sw8_clean_o (sw8_clean_o),
        .cap_cnt_o   (cap_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Applies the rules for one rising edge, using the values present just before it.
    task automatic model_edge();
        logic         seen;
        logic [N-1:0] seen_sws;
        logic         pressed_now, released_now;
        if (!reset) begin
            m_pin_hist[0] = 1'b0; m_pin_hist[1] = 1'b0;
            m_sws_hist[0] = '0;   m_sws_hist[1] = '0;
            m_stable = 1'b0; m_stable_prev = 1'b0;
            m_valid = 1'b0; m_need_rel = 1'b0;
            m_data = '0; m_cnt = '0; m_run = 0;
            return;
        end
        seen         = m_pin_hist[1];
        seen_sws     = m_sws_hist[1];
        pressed_now  = m_stable && !m_stable_prev;
        released_now = !m_stable && m_stable_prev;
        if (m_valid) begin
            if (ready_i) begin
                m_valid    = 1'b0;
                m_cnt      = m_cnt + 8'd1;
                m_need_rel = m_stable;
                $display("xfer data=%02h count=%0d", m_data, m_cnt);
            end
        end else if (m_need_rel) begin
            if (released_now) m_need_rel = 1'b0;
        end else if (pressed_now) begin
            m_valid = 1'b1;
            m_data  = seen_sws;
        end
        m_stable_prev = m_stable;
        m_pin_hist[1] = m_pin_hist[0];
        m_pin_hist[0] = sw8;
        m_sws_hist[1] = m_sws_hist[0];
        m_sws_hist[0] = sws;
        if (DEB) begin
            if (seen != m_stable) begin
                m_run++;
                if (m_run >= DB) begin
                    m_stable = seen;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            m_stable = m_pin_hist[1];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", valid_o, m_valid);
        chk("data", data_o, m_data);
        chk("clean", sw8_clean_o, m_stable);
        chk("cnt", cap_cnt_o, m_cnt);
    endtask

    task automatic run(input int n, output int vcyc, output int ccyc);
        vcyc = 0;
        ccyc = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid_o === 1'b1) vcyc++;
            if (sw8_clean_o === 1'b1) ccyc++;
        end
    endtask

    task automatic wait_valid(input int max, output int edge_no, output logic [N-1:0] d);
        edge_no = 0;
        d       = '0;
        for (int e = 1; e <= max; e++) begin
            tick();
            if (valid_o === 1'b1) begin
                edge_no = e;
                d       = data_o;
                break;
            end
        end
    endtask

    initial begin
        int           v, c, e, pre;
        logic [N-1:0] d;

        // Reset held with the switch already pressed
        reset = 1'b0; sw8 = 1'b1; sws = 8'h08; ready_i = 1'b1;
        tick();
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_cnt", cap_cnt_o, 0);
        reset = 1'b1;
        wait_valid(20, e, d);
        chk("rst_latency", e, LAT);
        chk("rst_data", d, 8'h08);

        // Single press with ready held high
        sw8 = 1'b0;
        run(DB + 4, v, c);
        sws = 8'b0000_1000;
        sw8 = 1'b1;
        run(10, v, c);
        chk("single_vcycles", v, 1);
        chk("single_cnt", cap_cnt_o, 2);
        // Short release must not re-arm
        sw8 = 1'b0;
        run(3, v, c);
        sw8 = 1'b1;
        run(8, pre, c);
        chk("short_release", v + pre, DEB ? 0 : 1);
        sw8 = 1'b0;
        run(DB + 4, v, c);

        // Glitch rejection
        sw8 = 1'b1;
        run(3, v, c);
        sw8 = 1'b0;
        run(10, pre, e);
        chk("glitch_valid", v + pre, DEB ? 0 : 1);
        chk("glitch_clean", c + e, DEB ? 0 : 3);

        // Backpressure: release and sws change while the offer waits
        ready_i = 1'b0;
        sws = 8'h04;
        sw8 = 1'b1;
        wait_valid(20, e, d);
        chk("bp_latency", e, LAT);
        run(DB + 3, v, c);
        sw8 = 1'b0;
        sws = 8'hFF;
        run(20 - e - (DB + 3), v, c);
        chk("bp_valid", valid_o, 1);
        chk("bp_data", data_o, 8'h04);
        ready_i = 1'b1;
        tick();
        chk("bp_drop", valid_o, 0);
        chk("bp_cnt", cap_cnt_o, DEB ? 3 : 5);
        sws = 8'h3C;
        sw8 = 1'b1;
        wait_valid(20, e, d);
        chk("bp_rearm_latency", e, LAT);
        chk("bp_rearm_data", d, 8'h3C);
        sw8 = 1'b0;
        run(DB + 4, v, c);

        // Reset in the middle of an offer drops it
        ready_i = 1'b0;
        sw8 = 1'b1;
        wait_valid(20, e, d);
        reset = 1'b0;
        tick();
        chk("midrst_valid", valid_o, 0);
        chk("midrst_cnt", cap_cnt_o, 0);
        reset = 1'b1;
        sw8 = 1'b0;
        ready_i = 1'b1;
        run(DB + 4, v, c);

        // 256 accepted presses: count goes 1, 2, ... and wraps to 0
        for (int p = 1; p <= 256; p++) begin
            sws = (p == 1) ? 8'h08 : (p == 2) ? 8'h04 : 8'($urandom_range(0, 255));
            sw8 = 1'b1;
            run(DB + 4, v, c);
            chk("press_once", v, 1);
            if (p <= 2) chk("press_cnt", cap_cnt_o, p);
            sw8 = 1'b0;
            run(DB + 4, v, c);
        end
        chk("wrap_cnt", cap_cnt_o, 0);

        // Random bouncing switch, random operands and random readiness
        for (int i = 0; i < 300; i++) begin
            sw8 = 1'($urandom_range(0, 1));
            e = $urandom_range(1, 2 * DB + 2);
            for (int k = 0; k < e; k++) begin
                sws     = 8'($urandom_range(0, 255));
                ready_i = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
